// File: rtl/mod_exp_pkg.sv
// Shared state encoding and default modulus constants for the mod_exp core
// and its mod_mul multiplier.
package mod_exp_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_SCAN      = 3'd1;
    localparam state_t ST_SQR_ISSUE = 3'd2;
    localparam state_t ST_SQR_WAIT  = 3'd3;
    localparam state_t ST_MUL_ISSUE = 3'd4;
    localparam state_t ST_MUL_WAIT  = 3'd5;
    localparam state_t ST_FIN       = 3'd6;

    localparam int         N_BIT_DEF = 7;
    localparam int         E_BIT_DEF = 8;
    localparam int         LOGR_DEF  = 5;
    localparam logic [6:0] N_DEF     = 7'd79;
    localparam logic [4:0] P_DEF     = 5'd17;
    localparam logic [6:0] R2_DEF    = 7'd9;

endpackage

// File: rtl/mod_mul.sv
// Plain-domain modular multiplier z = x*y mod n, built from two digit-serial
// Montgomery passes: mont(mont(x, y), R^2 mod n).
import mod_exp_pkg::*;

module mod_mul #(
    parameter int               n_bit  = N_BIT_DEF,
    parameter logic [n_bit-1:0] n      = N_DEF,
    parameter int               logr   = LOGR_DEF,
    parameter logic [logr-1:0]  p      = P_DEF,
    parameter logic [n_bit-1:0] R2modn = R2_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [n_bit-1:0] x,
    input  logic [n_bit-1:0] y,
    output logic [n_bit-1:0] z,
    output logic             done
);

    localparam int K  = (n_bit + logr - 1) / logr;
    localparam int KW = K * logr;
    localparam int TW = n_bit + logr + 2;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    logic [TW-1:0]     acc;
    logic [n_bit-1:0]  opa;
    logic [KW-1:0]     opb;
    logic [CW-1:0]     cnt;
    logic              phase;
    logic              run;

    logic [logr-1:0]   digit;
    logic [logr-1:0]   q;
    logic [2*logr-1:0] qp;
    logic [TW-1:0]     sum;
    logic [TW-1:0]     nxt;
    logic [n_bit-1:0]  red;

    // One radix-2^logr Montgomery step per cycle; the accumulator stays below 2n.
    always_comb begin
        digit = opb[logr-1:0];
        sum   = acc + TW'(opa) * TW'(digit);
        qp    = {{logr{1'b0}}, sum[logr-1:0]} * {{logr{1'b0}}, p};
        q     = qp[logr-1:0];
        nxt   = (sum + TW'(q) * TW'(n)) >> logr;
        red   = (nxt >= TW'(n)) ? n_bit'(nxt - TW'(n)) : n_bit'(nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            opa   <= '0;
            opb   <= '0;
            cnt   <= '0;
            phase <= 1'b0;
            run   <= 1'b0;
            z     <= '0;
            done  <= 1'b0;
        end else begin
            if (!start)
                done <= 1'b0;
            if (run) begin
                acc <= nxt;
                opb <= opb >> logr;
                cnt <= cnt + CW'(1);
                if (cnt == CW'(K - 1)) begin
                    acc <= '0;
                    cnt <= '0;
                    if (!phase) begin
                        opa   <= red;
                        opb   <= KW'(R2modn);
                        phase <= 1'b1;
                    end else begin
                        z    <= red;
                        done <= 1'b1;
                        run  <= 1'b0;
                    end
                end
            end else if (start && !done) begin
                run   <= 1'b1;
                phase <= 1'b0;
                acc   <= '0;
                cnt   <= '0;
                opa   <= x;
                opb   <= KW'(y);
            end
        end
    end

endmodule

// File: rtl/mod_exp.sv
// RSA core: c = m^e mod n by left-to-right square-and-multiply over one mod_mul.
// Define MOD_EXP_LEADING_SKIP_EN to skip leading zero exponent bits.
import mod_exp_pkg::*;

module mod_exp #(
    parameter int               n_bit  = N_BIT_DEF,
    parameter int               e_bit  = E_BIT_DEF,
    parameter logic [n_bit-1:0] n      = N_DEF,
    parameter int               logr   = LOGR_DEF,
    parameter logic [logr-1:0]  p      = P_DEF,
    parameter logic [n_bit-1:0] R2modn = R2_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [n_bit-1:0] m,
    input  logic [e_bit-1:0] e,
    output logic [n_bit-1:0] c,
    output logic             done,
    output logic             busy
);

    localparam int IW = (e_bit > 1) ? $clog2(e_bit) : 1;

    state_t           state;
    logic [n_bit-1:0] mreg;
    logic [e_bit-1:0] ereg;
    logic [n_bit-1:0] r;
    logic [IW-1:0]    i;
    logic [n_bit-1:0] x;
    logic [n_bit-1:0] y;
    logic [n_bit-1:0] z;
    logic             mm_start;
    logic             mm_done;
`ifdef MOD_EXP_LEADING_SKIP_EN
    logic             seen;
`endif

    mod_mul #(
        .n_bit  (n_bit),
        .n      (n),
        .logr   (logr),
        .p      (p),
        .R2modn (R2modn)
    ) inst_mod_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mm_start),
        .x     (x),
        .y     (y),
        .z     (z),
        .done  (mm_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mreg     <= '0;
            ereg     <= '0;
            r        <= '0;
            i        <= '0;
            x        <= '0;
            y        <= '0;
            mm_start <= 1'b0;
            c        <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
`ifdef MOD_EXP_LEADING_SKIP_EN
            seen     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mreg  <= m;
                        ereg  <= e;
                        r     <= n_bit'(1);
                        i     <= IW'(e_bit - 1);
                        busy  <= 1'b1;
                        state <= ST_SCAN;
`ifdef MOD_EXP_LEADING_SKIP_EN
                        seen  <= 1'b0;
`endif
                    end
                end
                ST_SCAN: begin
`ifdef MOD_EXP_LEADING_SKIP_EN
                    // Until the first set bit, r is either 1 or m: no multiply needed.
                    if (!seen) begin
                        if (ereg[i]) begin
                            r    <= mreg;
                            seen <= 1'b1;
                        end
                        if (i == '0)
                            state <= ST_FIN;
                        else
                            i <= i - IW'(1);
                    end else begin
                        state <= ST_SQR_ISSUE;
                    end
`else
                    state <= ST_SQR_ISSUE;
`endif
                end
                ST_SQR_ISSUE: begin
                    x        <= r;
                    y        <= r;
                    mm_start <= 1'b1;
                    state    <= ST_SQR_WAIT;
                end
                ST_SQR_WAIT: begin
                    if (mm_done) begin
                        r        <= z;
                        mm_start <= 1'b0;
                        if (ereg[i])
                            state <= ST_MUL_ISSUE;
                        else if (i == '0)
                            state <= ST_FIN;
                        else begin
                            i     <= i - IW'(1);
                            state <= ST_SCAN;
                        end
                    end
                end
                ST_MUL_ISSUE: begin
                    x        <= r;
                    y        <= mreg;
                    mm_start <= 1'b1;
                    state    <= ST_MUL_WAIT;
                end
                ST_MUL_WAIT: begin
                    if (mm_done) begin
                        r        <= z;
                        mm_start <= 1'b0;
                        if (i == '0)
                            state <= ST_FIN;
                        else begin
                            i     <= i - IW'(1);
                            state <= ST_SCAN;
                        end
                    end
                end
                ST_FIN: begin
                    c     <= r;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp.sv
// Scoreboard bench for mod_exp: expected c values queued at launch, popped on done.
import mod_exp_pkg::*;

module tb_mod_exp;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] m_i = '0;
    logic [7:0] e_i = '0;
    logic [6:0] c;
    logic       done;
    logic       busy;

    int         n_checks = 0;
    int         n_fail = 0;
    int         calls = 0;
    logic       mm_prev = 1'b0;
    logic [6:0] exp_q[$];

    mod_exp dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .m     (m_i),
        .e     (e_i),
        .c     (c),
        .done  (done),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dut.mm_start && !mm_prev)
            calls++;
        mm_prev = dut.mm_start;
    end

    function automatic logic [6:0] model_exp(input logic [6:0] mv, input logic [7:0] ev);
        int acc = 1;
        for (int k = 0; k < int'(ev); k++)
            acc = (acc * int'(mv)) % 79;
        return 7'(acc);
    endfunction

    function automatic int model_calls(input logic [7:0] ev);
        int pc = 0;
        int msb = -1;
        for (int k = 0; k < 8; k++)
            if (ev[k]) begin
                pc++;
                msb = k;
            end
`ifdef MOD_EXP_LEADING_SKIP_EN
        return (msb < 0) ? 0 : msb + pc - 1;
`else
        return 8 + pc;
`endif
    endfunction

    task automatic launch(input logic [6:0] mv, input logic [7:0] ev, input bit hold);
        @(negedge clk);
        m_i   = mv;
        e_i   = ev;
        start = 1'b1;
        calls = 0;
        exp_q.push_back(model_exp(mv, ev));
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (c !== 7'd0) begin n_fail++; $display("FAIL reset_c got %0d want 0", c); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++;
        if (dut.mm_start !== 1'b0) begin n_fail++; $display("FAIL reset_mm_start got %b want 0", dut.mm_start); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single(input string name, input logic [6:0] mv, input logic [7:0] ev);
        bit ok;
        logic [6:0] expv;
        launch(mv, ev, 1'b0);
        wait_done(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout no done seen", name);
            void'(exp_q.pop_front());
        end else begin
            expv = exp_q.pop_front();
            n_checks++;
            if (c !== expv) begin n_fail++; $display("FAIL %s_c got %0d want %0d", name, c, expv); end
            n_checks++;
            if (calls !== model_calls(ev)) begin
                n_fail++; $display("FAIL %s_calls got %0d want %0d", name, calls, model_calls(ev));
            end
            n_checks++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_at_done got %b want 0", name, busy); end
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL %s_done_pulse got %b want 0", name, done); end
            n_checks++;
            if (c !== expv) begin n_fail++; $display("FAIL %s_c_hold got %0d want %0d", name, c, expv); end
        end
    endtask

    task automatic test_constants();
        n_checks++;
        if (model_exp(7'd17, 8'd3) !== 7'd15) begin n_fail++; $display("FAIL model_17_3 got %0d want 15", model_exp(7'd17, 8'd3)); end
        n_checks++;
        if (model_exp(7'd2, 8'hFF) !== 7'd18) begin n_fail++; $display("FAIL model_2_ff got %0d want 18", model_exp(7'd2, 8'hFF)); end
    endtask

    task automatic test_start_while_busy();
        bit ok;
        logic [6:0] expv;
        launch(7'd17, 8'd3, 1'b0);
        repeat (4) @(negedge clk);
        m_i   = 7'd5;
        e_i   = 8'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_ignore_busy got %b want 1", busy); end
        wait_done(ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL busy_ignore_timeout no done seen");
            void'(exp_q.pop_front());
        end else begin
            expv = exp_q.pop_front();
            n_checks++;
            if (c !== expv) begin n_fail++; $display("FAIL busy_ignore_c got %0d want %0d", c, expv); end
        end
        test_single("after_ignore_5_2", 7'd5, 8'd2);
    endtask

    task automatic test_reset_mid_op();
        bit found = 1'b0;
        launch(7'd2, 8'hFF, 1'b0);
        void'(exp_q.pop_back());
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (dut.state === ST_MUL_WAIT) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL rst_mid_reach MUL_WAIT not reached"); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (c !== 7'd0) begin n_fail++; $display("FAIL rst_mid_c got %0d want 0", c); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got %b want 0", done); end
        n_checks++;
        if (dut.mm_start !== 1'b0) begin n_fail++; $display("FAIL rst_mid_mm_start got %b want 0", dut.mm_start); end
        @(negedge clk);
        rst_n = 1'b1;
        test_single("after_rst_17_3", 7'd17, 8'd3);
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [6:0] expv;
        launch(7'd17, 8'd3, 1'b1);
        wait_done(ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL b2b_first_timeout no done seen");
            void'(exp_q.pop_front());
        end else begin
            expv = exp_q.pop_front();
            n_checks++;
            if (c !== expv) begin n_fail++; $display("FAIL b2b_first_c got %0d want %0d", c, expv); end
        end
        m_i = 7'd2;
        e_i = 8'hFF;
        exp_q.push_back(model_exp(7'd2, 8'hFF));
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_busy got %b want 1", busy); end
        wait_done(ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL b2b_second_timeout no done seen");
            void'(exp_q.pop_front());
        end else begin
            expv = exp_q.pop_front();
            n_checks++;
            if (c !== expv) begin n_fail++; $display("FAIL b2b_second_c got %0d want %0d", c, expv); end
        end
    endtask

    initial begin
        test_reset();
        test_constants();
        test_single("m17_e3", 7'd17, 8'd3);
        test_single("m2_eff", 7'd2, 8'hFF);
        test_single("m17_e0", 7'd17, 8'd0);
        test_single("m0_e5", 7'd0, 8'd5);
        test_single("m42_e1", 7'd42, 8'd1);
        test_start_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_exp.md
Name: mod_exp

Overview:
- Computes c = m^e mod n by left-to-right binary square-and-multiply.
- Sequences one instantiated mod_mul through the start/done handshake.
- Sits directly upstream of mod_mul as its only driver; this is the RSA encrypt/decrypt core seen by the top level.
- Holds the running result, the latched base and the latched exponent; mod_mul performs all arithmetic.

Parameters:
- n, 7'd79, modulus; must be odd and >1; passed to mod_mul.
- n_bit, 7, width of the modulus, base and result.
- e_bit, 8, width of the exponent.
- logr, 5, mod_mul radix log2; passed through.
- p, 5'd17, Montgomery constant -n^-1 mod 2^logr; passed through.
- R2modn, 7'd9, R^2 mod n; passed through.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- m  in  n_bit  base; must be < n; captured when start is accepted.
- e  in  e_bit  exponent; captured when start is accepted.
- c  out  n_bit  result; valid while done=1 and held until the next accepted start.
- done  out  1  one-cycle pulse when c is valid.
- busy  out  1  high from the cycle after start is accepted until done.

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: c=0, done=0, busy=0, state IDLE, mm_start=0, all internal registers 0.
- mod_mul contract:
  - Computes z = x*y mod n in the plain domain.
  - x and y must be stable while its start is high.
  - Its done rises once the result is valid.
- Handshake rule for every mod_mul operation:
  - ISSUE cycle: mm_start=0, x/y registers loaded.
  - WAIT: mm_start=1 held until mm_done=1 is sampled.
  - On that edge, z is captured into r and mm_start returns to 0.
- State machine:
  - IDLE: on start=1, latch m into mreg and e into ereg, set r=1, bit index i=e_bit-1, busy=1, go to SCAN.
  - SCAN: decides the next step from i and ereg[i].
    - Leading-skip mode, no set bit seen yet:
      - ereg[i]=0 and i>0: i--, stay in SCAN.
      - ereg[i]=0 and i=0: go to FIN.
      - ereg[i]=1: r=mreg, mark seen; if i=0 go to FIN, else i--, stay in SCAN.
    - Otherwise: go to SQR_ISSUE.
  - SQR_ISSUE then SQR_WAIT: operands x=r, y=r.
    - If ereg[i]=1, go to MUL_ISSUE.
    - Else if i=0, go to FIN.
    - Else i--, go to SCAN.
  - MUL_ISSUE then MUL_WAIT: operands x=r, y=mreg.
    - If i=0, go to FIN.
    - Else i--, go to SCAN.
  - FIN: c=r, done=1 for exactly one cycle, busy=0, go to IDLE.
- Boundary results:
  - e=0 gives c=1.
  - m=0 with e>0 gives c=0.
  - e=1 gives c=m.
- start while busy: ignored, with no effect on m/e capture.
- start held high continuously: a new operation is accepted on the cycle after FIN, i.e. back-to-back.
- rst_n low mid-operation: immediate return to IDLE with reset values. mm_start drops asynchronously, so mod_mul sees start=0 and is reset by the same rst_n.
- Index i must not underflow; all decrements are guarded by the i=0 checks above.

Optional Feature:
- MOD_EXP_LEADING_SKIP_EN defined:
  - SCAN skips leading zero bits of ereg.
  - The first set bit loads r=mreg with no mod_mul call.
  - e=0 completes with no mod_mul call.
- Not defined:
  - Every bit from e_bit-1 down to 0 is processed: a square for every bit, plus a multiply for every set bit.
  - Starts from r=1.
- c is identical in both modes; only latency and mod_mul call count differ.

Decomposition:
- Shared package mod_exp_pkg: state encoding enum, and the default test constants (n=79, logr=5, p=17, R2modn=9).
- One sub-module, the existing mod_mul, instantiated once as inst_mod_mul.
- No other hierarchy.

Test Plan:
- m=17, e=3 -> c=15, one done pulse.
  - Skip mode: exactly 2 mod_mul calls.
  - Non-skip mode: 10 calls.
- m=2, e=8'hFF -> c=18.
- m=17, e=0 -> c=1; m=0, e=5 -> c=0; m=42, e=1 -> c=42.
- start pulsed again mid-run of m=17, e=3 with m=5 -> ignored; c=15. Then m=5, e=2 -> c=25 (5^2 = 25 < 79).
- rst_n low during MUL_WAIT of m=2, e=8'hFF:
  - c=0, busy=0, done=0, mm_start=0 immediately.
  - After release, new m=17, e=3 -> c=15.
- start held high across two operations (m=17, e=3 then m=2, e=8'hFF) -> two done pulses, c=15 then c=18, no idle gap beyond one cycle.
